retire_arb_n: RTL

- Parametrised retire arbiter for the NOU response path; successor to the fixed 4-unit retire controller.
- Merges NUM_CH SID-tagged result-register channels plus one receive-packet response channel into the RV response FIFO.
- Selects the oldest SID using wrap-around-safe age relative to head_sid.
- Bounds priority-channel preemption with a streak counter.
- Registers the winner in a one-entry output stage with a valid/ready handshake.

---
 rtl/retire_arb_n.sv | 107 ++++++++++
 1 files changed

// File: rtl/retire_arb_n.sv
// Retire arbiter: merges NUM_CH SID-tagged result channels and one priority
// (receive-packet) channel into a single registered response stage.
module retire_arb_n #(
  parameter int NUM_CH  = 4,
  parameter int SID_W   = 8,
  parameter int DATA_W  = 64,
  parameter int UOV_W   = 5,
  parameter int PRI_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_vld,
  input  logic [NUM_CH*SID_W-1:0]      ch_sid,
  input  logic [NUM_CH*DATA_W-1:0]     ch_data,
  input  logic [NUM_CH*UOV_W-1:0]      ch_uov,
  output logic [NUM_CH-1:0]            ch_rdy,
  input  logic                         pri_vld,
  input  logic [DATA_W-1:0]            pri_data,
  output logic                         pri_rdy,
  input  logic [SID_W-1:0]             head_sid,
  output logic                         out_vld,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(NUM_CH+1)-1:0]  out_src,
  output logic [UOV_W-1:0]             out_uov,
  input  logic                         out_rdy
);

  localparam int SRC_W = $clog2(NUM_CH+1);

  // Handshake: a transfer happens in a cycle where vld and rdy are both high;
  // requesters hold vld and payload stable until they see rdy.
  logic              ld;
  logic              any_ch;
  logic              take_pri;
  logic              grant_ch;
  logic [3:0]        pri_streak;
  logic [SID_W-1:0]  age;
  logic [SID_W-1:0]  best_age;
  int                best_i;
  logic [DATA_W-1:0] sel_data;
  logic [UOV_W-1:0]  sel_uov;

  assign ld = rst_n & (~out_vld | out_rdy);

  // Age is the modular distance from head_sid, so SID wrap needs no special case.
  always_comb begin
    age      = '0;
    best_age = '1;
    best_i   = 0;
    any_ch   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      age = ch_sid[i*SID_W +: SID_W] - head_sid;
      if (ch_vld[i] && (!any_ch || age < best_age)) begin
        any_ch   = 1'b1;
        best_age = age;
        best_i   = i;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_uov  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i == best_i) begin
        sel_data = ch_data[i*DATA_W +: DATA_W];
        sel_uov  = ch_uov[i*UOV_W +: UOV_W];
      end
    end
  end

  // Priority channel yields once it has won PRI_MAX times in a row over waiting SID traffic.
  assign take_pri = pri_vld & ~((pri_streak == 4'(PRI_MAX)) & any_ch);
  assign pri_rdy  = ld & take_pri;
  assign grant_ch = ld & ~take_pri & any_ch;
  assign ch_rdy   = grant_ch ? (NUM_CH'(1) << best_i) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld    <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      out_uov    <= '0;
      pri_streak <= '0;
    end else if (ld) begin
      if (pri_rdy) begin
        out_vld  <= 1'b1;
        out_data <= pri_data;
        out_src  <= SRC_W'(NUM_CH);
        out_uov  <= '0;
      end else if (grant_ch) begin
        out_vld  <= 1'b1;
        out_data <= sel_data;
        out_src  <= SRC_W'(best_i);
        out_uov  <= sel_uov;
      end else begin
        out_vld  <= 1'b0;
      end

      if (!pri_vld || grant_ch)
        pri_streak <= '0;
      else if (pri_rdy && any_ch && pri_streak != 4'(PRI_MAX))
        pri_streak <= pri_streak + 4'd1;
    end
  end

endmodule
